// File: rtl/rg_pkg.sv
// Shared definitions for the rg register-interface blocks: FSM encoding,
// serial idle level and the counter-width helper.
package rg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic SDO_IDLE = 1'b1;

  // Bit-counter width for a W-bit word; never narrower than one bit.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/rg_shreg.sv
// W-bit left-shift register with parallel load, shift and clock enable.
// Load has priority over shift; zeros enter at the LSB.
module rg_shreg #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      if (load) begin
        q <= d;
      end else if (shift) begin
        q <= q << 1;
      end
    end
  end

endmodule

// File: rtl/rg_piso_tx.sv
// Parallel-in/serial-out transmitter, MSB first, framed by frame/done with a
// valid/ready parallel side. Define RG_PISO_PARITY_EN to append even parity.
module rg_piso_tx
  import rg_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  input  logic         valid,
  output logic         ready,
  output logic         sdo,
  output logic         frame,
  output logic         done
);

  localparam int              CNT_W    = cnt_w(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     word;
  logic             accept;
  logic             shift;

  assign accept = valid & ready;
  assign shift  = (state == ST_SHIFT);

  rg_shreg #(.W(W)) u_shreg (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .load  (accept),
    .shift (shift),
    .d     (d),
    .q     (word)
  );

  // The counter holds at zero; the FSM leaves SHIFT on that same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (en) begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CNT_LAST;
      end else if (shift && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef RG_PISO_PARITY_EN
  logic par;

  // Parity is frozen at accept so it matches the word actually sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par <= 1'b0;
    end else if (en && accept) begin
      par <= ^d;
    end
  end
`endif

  // NOTE: every output and the next state get a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    sdo       = SDO_IDLE;
    frame     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        frame = 1'b1;
        sdo   = word[W-1];
        if (cnt == '0) begin
`ifdef RG_PISO_PARITY_EN
          state_nxt = ST_PAR;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
`ifdef RG_PISO_PARITY_EN
      ST_PAR: begin
        frame     = 1'b1;
        sdo       = par;
        state_nxt = ST_DONE;
      end
`endif
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rg_piso_tx.sv
// Scoreboard bench for rg_piso_tx: a per-cycle output model plus a frame-level
// queue, fed by directed and random stimulus. Honors RG_PISO_PARITY_EN.
module tb_rg_piso_tx;

  localparam int W = 3;
`ifdef RG_PISO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic sdo;
    logic frame;
    logic done;
  } line_t;

  typedef struct {
    logic [31:0] bits;
    int          n;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         valid;
  logic [W-1:0] d;
  logic         ready;
  logic         sdo;
  logic         frame;
  logic         done;

  int checks = 0;
  int errors = 0;
  int accepts = 0;
  int frames_seen = 0;

  line_t  exp_q[$];    // expected outputs, one entry per enabled cycle
  frame_t frame_q[$];  // expected completed frames

  rg_piso_tx #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .d     (d),
    .valid (valid),
    .ready (ready),
    .sdo   (sdo),
    .frame (frame),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A word becomes its bit sequence, optional parity, then one DONE cycle.
  task automatic push_word(input logic [W-1:0] w);
    frame_t f;
    f.bits = '0;
    f.n    = 0;
    for (int i = W - 1; i >= 0; i--) begin
      exp_q.push_back(line_t'{w[i], 1'b1, 1'b0});
      f.bits = {f.bits[30:0], w[i]};
      f.n++;
    end
    if (PAR_EN) begin
      exp_q.push_back(line_t'{^w, 1'b1, 1'b0});
      f.bits = {f.bits[30:0], ^w};
      f.n++;
    end
    exp_q.push_back(line_t'{1'b1, 1'b0, 1'b1});
    frame_q.push_back(f);
    accepts++;
  endtask

  // Reference model: busy while any expected cycle is pending.
  bit model_idle;
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      exp_q.delete();
      frame_q.delete();
    end else if (en) begin
      model_idle = (exp_q.size() == 0);
      if (!model_idle) begin
        void'(exp_q.pop_front());
      end else if (valid) begin
        push_word(d);
      end
    end
  end

  // Monitor: per-cycle output comparison and frame reassembly.
  logic [31:0] cur_bits;
  int          cur_n;
  logic [3:0]  e;
  frame_t      got;
  initial begin
    cur_bits = '0;
    cur_n    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cur_bits = '0;
        cur_n    = 0;
        check("reset_outputs", 32'({ready, frame, sdo, done}), 32'(4'b1010));
      end else begin
        if (exp_q.size() == 0) e = 4'b1010;
        else e = {1'b0, exp_q[0].frame, exp_q[0].sdo, exp_q[0].done};
        check("cycle_outputs", 32'({ready, frame, sdo, done}), 32'(e));
        if (en) begin
          if (frame) begin
            cur_bits = {cur_bits[30:0], sdo};
            cur_n++;
          end
          if (done) begin
            frames_seen++;
            if (frame_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL frame_unexpected: got done with no pending frame at %0t", $time);
            end else begin
              got = frame_q.pop_front();
              check("frame_bits", cur_bits, got.bits);
              check("frame_len", 32'(cur_n), 32'(got.n));
            end
            cur_bits = '0;
            cur_n    = 0;
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst   = 1'b0;
    en    = 1'b1;
    valid = 1'b1;
    d     = 3'b101;
    step(2);
    #1;
    check("rst_sdo",   32'(sdo),   32'(1));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_frame", 32'(frame), 32'(0));
    check("rst_done",  32'(done),  32'(0));
    step(1);
    rst   = 1'b1;
    valid = 1'b0;
    step(2);

    // Plain word 101.
    valid = 1'b1; d = 3'b101;
    step(1);
    valid = 1'b0;
    step(W + 4);

    // Freeze for two cycles right after the first bit of 110.
    valid = 1'b1; d = 3'b110;
    step(1);
    valid = 1'b0;
    en    = 1'b0;
    step(2);
    en = 1'b1;
    step(W + 4);

    // Valid with 011 held while 100 is in flight; taken only once idle.
    valid = 1'b1; d = 3'b100;
    step(1);
    d = 3'b011;
    step(W + 2);
    valid = 1'b0;
    step(W + 4);

    // Abort at the second bit, then send 111.
    valid = 1'b1; d = 3'b010;
    step(1);
    valid = 1'b0;
    step(1);
    rst = 1'b0;
    #1;
    check("abort_sdo",   32'(sdo),   32'(1));
    check("abort_frame", 32'(frame), 32'(0));
    check("abort_done",  32'(done),  32'(0));
    step(1);
    rst = 1'b1;
    step(1);
    valid = 1'b1; d = 3'b111;
    step(1);
    valid = 1'b0;
    step(W + 4);

    // Random traffic with enable gaps and occasional resets.
    repeat (500) begin
      en    = ($urandom_range(0, 7) != 0);
      valid = ($urandom_range(0, 2) == 0);
      d     = W'($urandom);
      rst   = ($urandom_range(0, 149) != 0);
      step(1);
    end

    rst   = 1'b1;
    en    = 1'b1;
    valid = 1'b0;
    step(W + 6);
    check("frames_pending", 32'(frame_q.size()), 32'(0));
    check("cycles_pending", 32'(exp_q.size()), 32'(0));
    check("frames_seen_nonzero", 32'(frames_seen > 10), 32'(1));
    check("accepts_nonzero", 32'(accepts > 10), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
